// File: rtl/address_generator_pkg.sv
// Shared types and constants for the march-element address generator.
// The Gray encoder is reused by future data-background logic.
package address_generator_pkg;

  localparam int ADDR_WIDTH = 10;

  typedef enum logic [1:0] {
    AG_IDLE = 2'd0,
    AG_RUN  = 2'd1,
    AG_DONE = 2'd2
  } ag_state_e;

  localparam logic ADMD_LINEAR = 1'b0;
  localparam logic ADMD_GRAY   = 1'b1;
  localparam logic UPDWN_UP    = 1'b1;

endpackage

// File: rtl/gray_encoder.sv
// Combinational binary-to-Gray conversion.
module gray_encoder #(
  parameter int aw = 10
) (
  input  logic [aw-1:0] bin_i,
  output logic [aw-1:0] gray_o
);

  assign gray_o = bin_i ^ (bin_i >> 1);

endmodule

// File: rtl/address_generator.sv
// Steps the memory address through one march element, up or down, in binary or Gray order,
// and pulses done_out when the terminal address has been stepped past.
module address_generator
  import address_generator_pkg::*;
#(
  parameter int aw   = ADDR_WIDTH,
  parameter int amax = (1 << aw) - 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_in,
  input  logic          updwn_in,
  input  logic          admd_in,
  input  logic          step_in,
  output logic [aw-1:0] addr_out,
  output logic          last_out,
  output logic          busy_out,
  output logic          done_out
);

  localparam logic [aw-1:0] AmaxC = aw'(amax);

  ag_state_e     state_q, state_d;
  logic [aw-1:0] count_q, count_d;
  logic [aw-1:0] addr_q, addr_d;
  logic [aw-1:0] gray_w;
  logic [aw-1:0] terminal_w;
  logic          dir_q, dir_d;
  logic          mode_q, mode_d;
  logic          at_term_w;

  assign terminal_w = (dir_q == UPDWN_UP) ? AmaxC : '0;
  assign at_term_w  = (count_q == terminal_w);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= AG_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // start_in wins over everything, including a same-cycle step and the DONE cycle.
  always_comb begin
    state_d = state_q;
    if (start_in) begin
      state_d = AG_RUN;
    end else begin
      unique case (state_q)
        AG_IDLE: state_d = AG_IDLE;
        AG_RUN:  if (step_in && at_term_w) state_d = AG_DONE;
        AG_DONE: state_d = AG_IDLE;
        default: state_d = AG_IDLE;
      endcase
    end
  end

  always_comb begin
    dir_d   = dir_q;
    mode_d  = mode_q;
    count_d = count_q;
    if (start_in) begin
      dir_d   = updwn_in;
      mode_d  = admd_in;
      count_d = (updwn_in == UPDWN_UP) ? '0 : AmaxC;
    end else if ((state_q == AG_RUN) && step_in && !at_term_w) begin
      count_d = (dir_q == UPDWN_UP) ? (count_q + aw'(1)) : (count_q - aw'(1));
    end
  end

  gray_encoder #(.aw(aw)) u_gray (
    .bin_i  (count_d),
    .gray_o (gray_w)
  );

  // Encoding the next count keeps addr_out a plain register with the same latency as count.
  assign addr_d = (mode_d == ADMD_GRAY) ? gray_w : count_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      addr_q  <= '0;
      dir_q   <= UPDWN_UP;
      mode_q  <= ADMD_LINEAR;
    end else begin
      count_q <= count_d;
      addr_q  <= addr_d;
      dir_q   <= dir_d;
      mode_q  <= mode_d;
    end
  end

  always_comb begin
    busy_out = (state_q == AG_RUN);
    done_out = (state_q == AG_DONE);
    last_out = busy_out & at_term_w;
  end

  assign addr_out = addr_q;

endmodule

// File: tb/tb_address_generator.sv
// Directed self-checking bench: one instance with amax=7 and one with a single-address element.
module tb_address_generator;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       startIn = 1'b0;
  logic       updwnIn = 1'b1;
  logic       admdIn = 1'b0;
  logic       stepIn = 1'b0;
  logic [3:0] addrA, addrB;
  logic       lastA, busyA, doneA;
  logic       lastB, busyB, doneB;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  address_generator #(.aw(4), .amax(7)) dutA (
    .clk(clk), .rst(rst), .start_in(startIn), .updwn_in(updwnIn), .admd_in(admdIn),
    .step_in(stepIn), .addr_out(addrA), .last_out(lastA), .busy_out(busyA), .done_out(doneA)
  );

  address_generator #(.aw(4), .amax(0)) dutB (
    .clk(clk), .rst(rst), .start_in(startIn), .updwn_in(updwnIn), .admd_in(admdIn),
    .step_in(stepIn), .addr_out(addrB), .last_out(lastB), .busy_out(busyB), .done_out(doneB)
  );

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic startElement(input logic up, input logic gray);
    updwnIn = up;
    admdIn  = gray;
    startIn = 1'b1;
    tick();
    startIn = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    if (addrA !== 4'd0) begin errors++; $display("[TB] FAIL reset_addr got %0d want 0", addrA); end
    checks++;
    if ({busyA, lastA, doneA} !== 3'b000) begin
      errors++; $display("[TB] FAIL reset_flags got %b want 000", {busyA, lastA, doneA});
    end
    checks++;
  endtask

  task automatic test_ascending_linear();
    startElement(1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      if (addrA !== 4'(i)) begin errors++; $display("[TB] FAIL asc_addr%0d got %0d want %0d", i, addrA, i); end
      checks++;
      if (lastA !== (i == 7)) begin errors++; $display("[TB] FAIL asc_last%0d got %b want %b", i, lastA, (i == 7)); end
      checks++;
      if (busyA !== 1'b1) begin errors++; $display("[TB] FAIL asc_busy%0d got %b want 1", i, busyA); end
      checks++;
      stepIn = 1'b1;
      tick();
      stepIn = 1'b0;
      if (doneA !== (i == 7)) begin errors++; $display("[TB] FAIL asc_done%0d got %b want %b", i, doneA, (i == 7)); end
      checks++;
      tick();
      tick();
    end
    if ({busyA, lastA, doneA} !== 3'b000) begin
      errors++; $display("[TB] FAIL asc_after got %b want 000", {busyA, lastA, doneA});
    end
    checks++;
  endtask

  task automatic test_descending_gray();
    logic [3:0] expGray [8] = '{4'd4, 4'd5, 4'd7, 4'd6, 4'd2, 4'd3, 4'd1, 4'd0};
    startElement(1'b0, 1'b1);
    stepIn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (addrA !== expGray[i]) begin errors++; $display("[TB] FAIL gray_addr%0d got %0d want %0d", i, addrA, expGray[i]); end
      checks++;
      if (lastA !== (i == 7)) begin errors++; $display("[TB] FAIL gray_last%0d got %b want %b", i, lastA, (i == 7)); end
      checks++;
      if (doneA !== 1'b0) begin errors++; $display("[TB] FAIL gray_early_done%0d got %b want 0", i, doneA); end
      checks++;
      tick();
    end
    stepIn = 1'b0;
    if ({busyA, lastA, doneA} !== 3'b001) begin
      errors++; $display("[TB] FAIL gray_done got %b want 001", {busyA, lastA, doneA});
    end
    checks++;
    if (addrA !== 4'd0) begin errors++; $display("[TB] FAIL gray_hold got %0d want 0", addrA); end
    checks++;
    tick();
    if (doneA !== 1'b0) begin errors++; $display("[TB] FAIL gray_done_width got %b want 0", doneA); end
    checks++;
  endtask

  task automatic test_start_priority();
    startElement(1'b1, 1'b0);
    stepIn = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    stepIn = 1'b0;
    if (addrA !== 4'd5) begin errors++; $display("[TB] FAIL prio_pre got %0d want 5", addrA); end
    checks++;
    startIn = 1'b1;
    stepIn  = 1'b1;
    tick();
    startIn = 1'b0;
    stepIn  = 1'b0;
    if (addrA !== 4'd0) begin errors++; $display("[TB] FAIL prio_reload got %0d want 0", addrA); end
    checks++;
    if ({busyA, doneA} !== 2'b10) begin errors++; $display("[TB] FAIL prio_flags got %b want 10", {busyA, doneA}); end
    checks++;
    tick();
    if (addrA !== 4'd0) begin errors++; $display("[TB] FAIL prio_nostep got %0d want 0", addrA); end
    checks++;
  endtask

  task automatic test_reset_mid();
    startElement(1'b1, 1'b0);
    stepIn = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    stepIn = 1'b0;
    if (addrA !== 4'd3) begin errors++; $display("[TB] FAIL rstmid_pre got %0d want 3", addrA); end
    checks++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    if ({addrA, busyA, doneA} !== 6'd0) begin
      errors++; $display("[TB] FAIL rstmid_out got addr %0d busy %b done %b want 0 0 0", addrA, busyA, doneA);
    end
    checks++;
    for (int i = 0; i < 2; i++) begin
      stepIn = 1'b1;
      tick();
      stepIn = 1'b0;
      tick();
    end
    if ({addrA, busyA, doneA} !== 6'd0) begin
      errors++; $display("[TB] FAIL rstmid_ignore got addr %0d busy %b done %b want 0 0 0", addrA, busyA, doneA);
    end
    checks++;
  endtask

  task automatic test_single_address();
    startElement(1'b1, 1'b0);
    if ({addrB, busyB, lastB} !== 6'b0000_11) begin
      errors++; $display("[TB] FAIL single_start got addr %0d busy %b last %b want 0 1 1", addrB, busyB, lastB);
    end
    checks++;
    stepIn = 1'b1;
    tick();
    stepIn = 1'b0;
    if ({addrB, busyB, lastB, doneB} !== 7'b0000_001) begin
      errors++; $display("[TB] FAIL single_done got addr %0d busy %b last %b done %b want 0 0 0 1", addrB, busyB, lastB, doneB);
    end
    checks++;
    tick();
    if (doneB !== 1'b0) begin errors++; $display("[TB] FAIL single_done_width got %b want 0", doneB); end
    checks++;
  endtask

  task automatic test_idle_done_steps();
    startElement(1'b0, 1'b0);
    stepIn = 1'b1;
    tick();
    if (doneB !== 1'b1) begin errors++; $display("[TB] FAIL ids_done got %b want 1", doneB); end
    checks++;
    tick();
    if ({addrB, busyB, doneB} !== 6'd0) begin
      errors++; $display("[TB] FAIL ids_done_step got addr %0d busy %b done %b want 0 0 0", addrB, busyB, doneB);
    end
    checks++;
    tick();
    stepIn = 1'b0;
    if ({addrB, busyB, doneB} !== 6'd0) begin
      errors++; $display("[TB] FAIL ids_idle_step got addr %0d busy %b done %b want 0 0 0", addrB, busyB, doneB);
    end
    checks++;
    startElement(1'b1, 1'b0);
    stepIn = 1'b1;
    tick();
    stepIn  = 1'b0;
    startIn = 1'b1;
    if (doneB !== 1'b1) begin errors++; $display("[TB] FAIL ids_restart_done got %b want 1", doneB); end
    checks++;
    tick();
    startIn = 1'b0;
    if ({busyB, lastB, doneB} !== 3'b110) begin
      errors++; $display("[TB] FAIL ids_restart_run got %b want 110", {busyB, lastB, doneB});
    end
    checks++;
  endtask

  initial begin
    test_reset();
    test_ascending_linear();
    test_descending_gray();
    test_start_priority();
    test_reset_mid();
    test_single_address();
    test_idle_done_steps();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
